// File: rtl/paralelo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : paralelo_serial_tx
// Purpose  : Byte-to-bit serializer on clk8f, MSB first. After reset it sends
//            SYNC_COUNT comma bytes, then sends data or idle bytes.
//            Optional macro IDLE_COUNT_EN adds a saturating idle-insertion
//            counter output (idle_count).
// Revision : 1.0 - initial release
// ============================================================================
module paralelo_serial_tx #(
  parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       byte_strobe,
  output logic       accept,
  output logic       data_out,
`ifdef IDLE_COUNT_EN
  output logic [7:0] idle_count,
`endif
  output logic       active
);

  localparam logic [0:0] S_SYNC      = 1'b0;
  localparam logic [0:0] S_ACTIVE    = 1'b1;
  localparam logic [3:0] C_LAST_SYNC = 4'(SYNC_COUNT - 1);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q,   shreg_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic [0:0] state_q,   state_d;

  logic       w_load;
  logic       w_in_active;
  logic [7:0] w_next_byte;

  // The byte boundary is the last bit-cycle of the current byte.
  assign w_load      = (bit_cnt_q == 3'd7);
  assign w_in_active = (state_q == S_ACTIVE);
  assign w_next_byte = (w_in_active && valid_in) ? data_in : IDLE_CHAR;
  assign data_out    = shreg_q[7];

  // FSM: state register
  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC: begin
        if (w_load && (sync_cnt_q == C_LAST_SYNC)) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: state_d = S_ACTIVE;
      default:  state_d = S_SYNC;
    endcase
  end

  // FSM: outputs
  always_comb begin
    byte_strobe = w_load;
    active      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_SYNC:   active = 1'b0;
      S_ACTIVE: begin
        active = 1'b1;
        accept = w_load & valid_in;
      end
      default:  active = 1'b0;
    endcase
  end

  // Datapath next-state
  always_comb begin
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    if (w_load) begin
      shreg_d = w_next_byte;
      if (!w_in_active) begin
        sync_cnt_d = sync_cnt_q + 4'd1;
      end
    end else begin
      shreg_d = {shreg_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      sync_cnt_q <= 4'd0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

`ifdef IDLE_COUNT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  // Counts idles inserted for lack of valid data; comma bytes in SYNC excluded.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (w_load && w_in_active && !valid_in && (idle_cnt_q != 8'hFF)) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk8f or negedge reset_L) begin
    if (!reset_L) begin
      idle_cnt_q <= 8'h00;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign idle_count = idle_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_paralelo_serial_tx
// Purpose  : Randomized self-checking bench for paralelo_serial_tx against a
//            byte-level reference model (edge count -> byte slot -> bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_paralelo_serial_tx;

  localparam int         SC = 4;
  localparam logic [7:0] BC = 8'hBC;

  logic       clk8f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       byte_strobe, accept, data_out, active;
`ifdef IDLE_COUNT_EN
  logic [7:0] idle_count;
`endif

  paralelo_serial_tx #(.IDLE_CHAR(BC), .SYNC_COUNT(SC)) dut (
    .clk8f       (clk8f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .byte_strobe (byte_strobe),
    .accept      (accept),
    .data_out    (data_out),
`ifdef IDLE_COUNT_EN
    .idle_count  (idle_count),
`endif
    .active      (active)
  );

  always #5 clk8f = ~clk8f;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at t=%0t (edge %0d): got %0h expected %0h", tag, $time, m_n, got, exp);
  endtask

  // Reference model: m_n edges since reset release; a byte is loaded every 8th
  // edge, byte slots 1..SC are commas, later slots carry data or idle.
  int         m_n;
  logic [7:0] m_byte;
  int         m_idle;

  task automatic model_reset();
    m_n = 0; m_byte = 8'h00; m_idle = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    int slot;
    m_n++;
    if (m_n >= 8 && (m_n % 8) == 0) begin
      slot = m_n / 8;
      if (slot <= SC)  m_byte = BC;
      else if (v)      m_byte = d;
      else begin
        m_byte = BC;
        if (m_idle < 255) m_idle++;
      end
    end
  endtask

  task automatic check_outputs(input logic v);
    logic exp_bit, exp_strobe, exp_active;
    exp_bit    = (m_n < 8) ? 1'b0 : m_byte[7 - (m_n % 8)];
    exp_strobe = (m_n % 8) == 7;
    exp_active = m_n >= 8 * SC;
    check("data_out",    32'(data_out),    32'(exp_bit));
    check("byte_strobe", 32'(byte_strobe), 32'(exp_strobe));
    check("active",      32'(active),      32'(exp_active));
    check("accept",      32'(accept),      32'(exp_strobe & exp_active & v));
`ifdef IDLE_COUNT_EN
    check("idle_count",  32'(idle_count),  32'(m_idle));
`endif
  endtask

  // Called 1 time unit after a rising edge; drive, check, advance one edge.
  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    #1;
    check_outputs(v);
    @(posedge clk8f);
    model_edge(v, d);
    #1;
  endtask

  logic [8:0] bq[$];

  // mode 0: valid 0x55 at boundaries, 1: directed queue, 2: random, 3: idle.
  // Non-boundary cycles always get random garbage, which must be ignored.
  task automatic run(input int cycles, input int mode);
    logic       v;
    logic [7:0] d;
    logic [8:0] e;
    for (int i = 0; i < cycles; i++) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if ((m_n % 8) == 7) begin
        case (mode)
          0: begin v = 1'b1; d = 8'h55; end
          1: begin
            if (bq.size() > 0) begin e = bq.pop_front(); v = e[8]; d = e[7:0]; end
            else v = 1'b0;
          end
          3: v = 1'b0;
          default: ;
        endcase
      end
      step(v, d);
    end
  endtask

  initial begin
    reset_L = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk8f);
    #1;
    check_outputs(1'b0);
    @(negedge clk8f);
    reset_L = 1'b1;

    // SYNC with valid data offered: only commas, no accept
    run(8 * SC, 0);
    // Directed: A5, idle, then 00/FF/3C back-to-back, idle
    bq.push_back({1'b1, 8'hA5});
    bq.push_back({1'b0, 8'h00});
    bq.push_back({1'b1, 8'h00});
    bq.push_back({1'b1, 8'hFF});
    bq.push_back({1'b1, 8'h3C});
    bq.push_back({1'b0, 8'h11});
    run(8 * 7, 1);
    run(400, 2);

    // Asynchronous reset at bit 3 of a byte
    while ((m_n % 8) != 3) step(1'b1, 8'($urandom));
    #1 reset_L = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out),    32'd0);
    check("rst_active",   32'(active),      32'd0);
    check("rst_strobe",   32'(byte_strobe), 32'd0);
    check("rst_accept",   32'(accept),      32'd0);
    model_reset();
    @(negedge clk8f);
    reset_L = 1'b1;
    run(8 * SC, 0);
    run(200, 2);

`ifdef IDLE_COUNT_EN
    run(300 * 8 + 8, 3);
    check("idle_sat", 32'(idle_count), 32'd255);
    #1 reset_L = 1'b0;
    #1;
    check("idle_rst", 32'(idle_count), 32'd0);
    model_reset();
    @(negedge clk8f);
    reset_L = 1'b1;
    run(8 * SC + 16, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
